pipeline_retire: RTL and testbench

Terminal consumer for the stalling address pipeline. It sits directly downstream of the last `pipeline_stage` and accepts its address/ID beats into a small in-order retire FIFO. It drives that stage's `in_stall`, applies its forwarded flush to queued beats, and presents surviving beats to the sink over a valid/ready port. An optional in-order ID checker flags sequence gaps.

---
 rtl/pipeline_retire.sv | 136 +++++++++++++
 tb/tb_pipeline_retire.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_retire.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_retire
// Purpose  : Terminal retire FIFO for the stalling address pipeline. It applies
//            upstream flushes to queued beats and presents survivors to a sink.
//            Optional in-order ID checker is enabled by RETIRE_SEQ_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_retire #(
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_WIDTH     = 16,
    parameter int ADDRESS_WIDTH = 32,
    parameter int ID_WIDTH      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] in_address,
    input  logic [ID_WIDTH-1:0]      in_id,
    input  logic                     in_valid,
    output logic                     out_stall,
    input  logic                     in_flush,
    input  logic [ID_WIDTH-1:0]      in_flush_id,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic                     out_valid,
    input  logic                     in_ready,
    output logic [CNT_WIDTH-1:0]     retired_count,
    output logic                     seq_error
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_OCC_W = c_PTR_W + 1;
    localparam logic [c_OCC_W-1:0] c_FULL  = c_OCC_W'(FIFO_DEPTH);

    logic [ADDRESS_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]      mem_id_q   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]    kill_q;
    logic [c_PTR_W-1:0]       wr_ptr_q;
    logic [c_PTR_W-1:0]       rd_ptr_q;
    logic [c_OCC_W-1:0]       occ_q;
    logic [c_OCC_W-1:0]       occ_d;
    logic                     stall_q;
    logic [CNT_WIDTH-1:0]     count_q;

    logic w_nonempty;
    logic w_head_kill;
    logic w_valid;
    logic w_pop;
    logic w_discard;
    logic w_deq;
    logic w_push;

    assign w_nonempty  = (occ_q != '0);
    assign w_head_kill = kill_q[rd_ptr_q];
    assign w_valid     = w_nonempty && !w_head_kill;
    assign w_pop       = w_valid && in_ready;
    assign w_discard   = w_nonempty && w_head_kill;
    assign w_deq       = w_pop || w_discard;
    assign w_push      = in_valid && !stall_q;

    always_comb begin
        occ_d = occ_q;
        if (w_push && !w_deq) begin
            occ_d = occ_q + c_OCC_W'(1);
        end else if (!w_push && w_deq) begin
            occ_d = occ_q - c_OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kill_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            stall_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            // Flush may tag free slots too; harmless since a push rewrites the kill bit.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (in_flush && (mem_id_q[i] == in_flush_id)) begin
                    kill_q[i] <= 1'b1;
                end
            end
            if (w_push) begin
                kill_q[wr_ptr_q] <= in_flush && (in_id == in_flush_id);
                wr_ptr_q         <= wr_ptr_q + c_PTR_W'(1);
            end
            if (w_deq) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
            end
            if (w_pop) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end
            occ_q   <= occ_d;
            stall_q <= (occ_d == c_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_addr_q[wr_ptr_q] <= in_address;
            mem_id_q[wr_ptr_q]   <= in_id;
        end
    end

    assign out_stall     = stall_q;
    assign out_valid     = w_valid;
    assign out_address   = w_nonempty ? mem_addr_q[rd_ptr_q] : '0;
    assign out_id        = w_nonempty ? mem_id_q[rd_ptr_q] : '0;
    assign retired_count = count_q;

`ifdef RETIRE_SEQ_CHECK_EN
    logic [ID_WIDTH-1:0] exp_id_q;
    logic                seq_err_q;

    // Killed heads advance the expectation too, so a flushed ID is not a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_id_q  <= '0;
            seq_err_q <= 1'b0;
        end else if (w_deq) begin
            if (mem_id_q[rd_ptr_q] != exp_id_q) begin
                seq_err_q <= 1'b1;
            end
            exp_id_q <= mem_id_q[rd_ptr_q] + ID_WIDTH'(1);
        end
    end

    assign seq_error = seq_err_q;
`else
    assign seq_error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_retire.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_retire
// Purpose  : Table-driven self-checking bench for pipeline_retire
//            (FIFO_DEPTH=4), plus a hand sequence for the ID checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_retire;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] addr;
        logic [7:0]  id;
        logic        rdy;
        logic        fl;
        logic [7:0]  fid;
        logic        ov;
        logic [31:0] oa;
        logic [7:0]  oid;
        logic        st;
        logic [15:0] cnt;
    } vec_t;

`ifdef RETIRE_SEQ_CHECK_EN
    localparam logic c_SEQ_ON_GAP = 1'b1;
`else
    localparam logic c_SEQ_ON_GAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_address = '0;
    logic [7:0]  in_id = '0;
    logic        in_valid = 1'b0;
    logic        out_stall;
    logic        in_flush = 1'b0;
    logic [7:0]  in_flush_id = '0;
    logic [31:0] out_address;
    logic [7:0]  out_id;
    logic        out_valid;
    logic        in_ready = 1'b0;
    logic [15:0] retired_count;
    logic        seq_error;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vq[$];

    pipeline_retire #(
        .FIFO_DEPTH   (4),
        .CNT_WIDTH    (16),
        .ADDRESS_WIDTH(32),
        .ID_WIDTH     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_address   (in_address),
        .in_id        (in_id),
        .in_valid     (in_valid),
        .out_stall    (out_stall),
        .in_flush     (in_flush),
        .in_flush_id  (in_flush_id),
        .out_address  (out_address),
        .out_id       (out_id),
        .out_valid    (out_valid),
        .in_ready     (in_ready),
        .retired_count(retired_count),
        .seq_error    (seq_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input int rst, input int vld, input int addr, input int id,
                       input int rdy, input int fl, input int fid,
                       input int ov, input int oa, input int oid, input int st, input int cnt);
        vec_t v;
        v.rst = 1'(rst);  v.vld = 1'(vld);  v.addr = 32'(addr); v.id = 8'(id);
        v.rdy = 1'(rdy);  v.fl  = 1'(fl);   v.fid  = 8'(fid);
        v.ov  = 1'(ov);   v.oa  = 32'(oa);  v.oid  = 8'(oid);
        v.st  = 1'(st);   v.cnt = 16'(cnt);
        vq.push_back(v);
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic rst, input logic vld, input logic [31:0] addr,
                        input logic [7:0] id, input logic rdy, input logic fl,
                        input logic [7:0] fid);
        @(negedge clk);
        reset = rst; in_valid = vld; in_address = addr; in_id = id;
        in_ready = rdy; in_flush = fl; in_flush_id = fid;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst vld addr  id  rdy fl fid   ov  oa    oid st cnt
        add(1, 0, 0,     0,  0, 0, 0,     0, 0,     0,  0, 0);   // 0 reset
        add(0, 1, 'h10,  0,  1, 0, 0,     1, 'h10,  0,  0, 0);   // 1 first push
        add(0, 1, 'h20,  1,  1, 0, 0,     1, 'h20,  1,  0, 1);
        add(0, 1, 'h30,  2,  1, 0, 0,     1, 'h30,  2,  0, 2);
        add(0, 0, 0,     0,  1, 0, 0,     0, 0,     0,  0, 3);   // 4 drained
        add(0, 1, 'h40,  3,  0, 0, 0,     1, 'h40,  3,  0, 3);   // 5 fill
        add(0, 1, 'h50,  4,  0, 0, 0,     1, 'h40,  3,  0, 3);
        add(0, 1, 'h60,  5,  0, 0, 0,     1, 'h40,  3,  0, 3);
        add(0, 1, 'h70,  6,  0, 0, 0,     1, 'h40,  3,  1, 3);   // 8 full
        add(0, 1, 'h80,  7,  0, 0, 0,     1, 'h40,  3,  1, 3);   // 9 held
        add(0, 1, 'h80,  7,  1, 0, 0,     1, 'h50,  4,  0, 4);   // 10 pop, no push
        add(0, 1, 'h80,  7,  0, 0, 0,     1, 'h50,  4,  1, 4);   // 11 held beat taken
        add(0, 0, 0,     0,  1, 0, 0,     1, 'h60,  5,  0, 5);
        add(0, 0, 0,     0,  1, 0, 0,     1, 'h70,  6,  0, 6);
        add(0, 0, 0,     0,  1, 0, 0,     1, 'h80,  7,  0, 7);
        add(0, 0, 0,     0,  1, 0, 0,     0, 0,     0,  0, 8);   // 15 empty
        add(0, 1, 'h90,  8,  0, 0, 0,     1, 'h90,  8,  0, 8);   // 16 queue 8,9,10
        add(0, 1, 'hA0,  9,  0, 0, 0,     1, 'h90,  8,  0, 8);
        add(0, 1, 'hB0,  10, 0, 0, 0,     1, 'h90,  8,  0, 8);
        add(0, 0, 0,     0,  0, 1, 9,     1, 'h90,  8,  0, 8);   // 19 flush 9
        add(0, 0, 0,     0,  1, 0, 0,     0, 'hA0,  9,  0, 9);   // 20 killed head
        add(0, 0, 0,     0,  1, 0, 0,     1, 'hB0,  10, 0, 9);   // 21 discarded
        add(0, 0, 0,     0,  1, 0, 0,     0, 0,     0,  0, 10);
        add(0, 1, 'hC0,  11, 1, 1, 11,    0, 'hC0,  11, 0, 10);  // 23 flush on push
        add(0, 0, 0,     0,  1, 0, 0,     0, 0,     0,  0, 10);
        add(0, 1, 'hD0,  12, 0, 0, 0,     1, 'hD0,  12, 0, 10);  // 25 queue 3
        add(0, 1, 'hE0,  13, 0, 0, 0,     1, 'hD0,  12, 0, 10);
        add(0, 1, 'hF0,  14, 0, 0, 0,     1, 'hD0,  12, 0, 10);
        add(1, 1, 'hF1,  15, 1, 1, 12,    0, 0,     0,  0, 0);   // 28 reset wins
        add(0, 0, 0,     0,  0, 0, 0,     0, 0,     0,  0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].rst, vq[i].vld, vq[i].addr, vq[i].id, vq[i].rdy, vq[i].fl, vq[i].fid);
            check($sformatf("v%0d out_valid", i),     32'(out_valid),     32'(vq[i].ov));
            check($sformatf("v%0d out_address", i),   out_address,        vq[i].oa);
            check($sformatf("v%0d out_id", i),        32'(out_id),        32'(vq[i].oid));
            check($sformatf("v%0d out_stall", i),     32'(out_stall),     32'(vq[i].st));
            check($sformatf("v%0d retired_count", i), 32'(retired_count), 32'(vq[i].cnt));
            check($sformatf("v%0d seq_error", i),     32'(seq_error),     32'(0));
        end

        // IDs 0,1,3 with a flush of ID 0 while ID 0 is being popped.
        step(1'b0, 1'b1, 32'h100, 8'd0, 1'b1, 1'b0, 8'd0);
        check("seq head0", 32'(out_id), 32'(0));
        step(1'b0, 1'b1, 32'h101, 8'd1, 1'b1, 1'b1, 8'd0);
        check("seq pop under flush cnt", 32'(retired_count), 32'(1));
        check("seq head1 valid", 32'(out_valid), 32'(1));
        step(1'b0, 1'b1, 32'h103, 8'd3, 1'b1, 1'b0, 8'd0);
        check("seq before gap", 32'(seq_error), 32'(0));
        check("seq head3 addr", out_address, 32'h103);
        step(1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 8'd0);
        check("seq after gap", 32'(seq_error), 32'(c_SEQ_ON_GAP));
        check("seq cnt", 32'(retired_count), 32'(3));
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 32'h0, 8'd0, 1'b1, 1'b0, 8'd0);
            check($sformatf("seq sticky %0d", k), 32'(seq_error), 32'(c_SEQ_ON_GAP));
        end
        step(1'b1, 1'b0, 32'h0, 8'd0, 1'b0, 1'b0, 8'd0);
        check("seq cleared by reset", 32'(seq_error), 32'(0));
        check("cnt cleared by reset", 32'(retired_count), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
